// File: rtl/inst_req_stage_pkg.sv
// inst_req_stage shared definitions
// Reset PC, AXI read-address constants and request-state encoding.
`timescale 1ns/1ps
package inst_req_stage_pkg;

    localparam logic [31:0] RESET_ADDR   = 32'hbfc00000;
    localparam logic [2:0]  ARID_INST    = 3'd0;
    localparam logic [7:0]  ARLEN_SINGLE = 8'd0;
    localparam logic [2:0]  ARSIZE_WORD  = 3'd2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        AR   = 2'd1,
        R    = 2'd2,
        HOLD = 2'd3
    } req_state_e;

endpackage

// File: rtl/inst_req_stage_if.sv
// inst_req_stage AXI bundle
// Instruction AR channel plus the shared R-channel valid/id/ready.
`timescale 1ns/1ps
interface inst_req_stage_if;

    logic        inst_arvalid;
    logic [31:0] inst_araddr;
    logic [2:0]  inst_arid;
    logic [7:0]  inst_arlen;
    logic [2:0]  inst_arsize;
    logic        inst_arready;
    logic        axi_rvalid;
    logic [2:0]  axi_rid;
    logic        axi_rready;

    modport master (
        output inst_arvalid, inst_araddr, inst_arid,
        output inst_arlen, inst_arsize,
        input  inst_arready,
        input  axi_rvalid, axi_rid, axi_rready
    );

    modport slave (
        input  inst_arvalid, inst_araddr, inst_arid,
        input  inst_arlen, inst_arsize,
        output inst_arready,
        output axi_rvalid, axi_rid, axi_rready
    );

endinterface

// File: rtl/inst_req_stage.sv
// inst_req_stage: owns fetch PC, issues single-beat instruction reads
// and drops R responses that belong to flushed requests.
`timescale 1ns/1ps
module inst_req_stage
    import inst_req_stage_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = inst_req_stage_pkg::RESET_ADDR
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [31:0]             PC_next,
    input  logic                    IRWrite,
    input  logic                    decode_allowin,
    input  logic                    IR_buffer_valid,
    input  logic                    exc_flush,
    input  logic [31:0]             exc_target,
    input  logic                    data_ar_busy,
    inst_req_stage_if.master        bus,
    output logic                    fetch_axi_rvalid,
    output logic [31:0]             PC_buffer,
    output logic                    PC_AdEL,
    output logic                    PC_abnormal
);

    req_state_e  state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        drop_q, drop_d;

    logic inst_resp;
    logic advance;

    assign inst_resp = bus.axi_rvalid && bus.axi_rready
                    && (bus.axi_rid == ARID_INST);
    assign advance   = IRWrite && decode_allowin && !IR_buffer_valid;

    assign bus.inst_arvalid = (state_q == AR);
    assign bus.inst_araddr  = {pc_q[31:2], 2'b00};
    assign bus.inst_arid    = ARID_INST;
    assign bus.inst_arlen   = ARLEN_SINGLE;
    assign bus.inst_arsize  = ARSIZE_WORD;

    assign fetch_axi_rvalid = bus.axi_rvalid
                           && !((bus.axi_rid == ARID_INST) && drop_q);

    assign PC_buffer   = pc_q;
    assign PC_AdEL     = (pc_q[1:0] != 2'b00);
    assign PC_abnormal = PC_AdEL;

    // Request sequencing; a flush retargets pc and kills the in-flight beat
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        drop_d  = drop_q;
        unique case (state_q)
            IDLE: if (!data_ar_busy) state_d = AR;
            AR:   if (bus.inst_arready) state_d = R;
            R: begin
                if (inst_resp) begin
                    state_d = drop_q ? IDLE : HOLD;
                    drop_d  = 1'b0;
                end
            end
            HOLD: begin
                if (advance) begin
                    state_d = IDLE;
                    pc_d    = PC_next;
                end
            end
            default: state_d = IDLE;
        endcase
        if (exc_flush) begin
            pc_d = exc_target;
            unique case (state_q)
                IDLE, HOLD: begin
                    state_d = IDLE;
                    drop_d  = 1'b0;
                end
                AR: drop_d = 1'b1;
                R: begin
                    if (inst_resp) state_d = IDLE;
                    else           drop_d  = 1'b1;
                end
                default: ;
            endcase
        end
    end

    // State, pc and drop registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pc_q    <= RESET_ADDR;
            drop_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            drop_q  <= drop_d;
        end
    end

endmodule

// File: tb/tb_inst_req_stage.sv
// Testbench for inst_req_stage: directed scenarios with fixed expected
// values, then random traffic against a transaction-level reference.
`timescale 1ns/1ps
module tb_inst_req_stage;

    localparam logic [31:0] RST_PC = 32'hbfc00000;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] PC_next;
    logic        IRWrite;
    logic        decode_allowin;
    logic        IR_buffer_valid;
    logic        exc_flush;
    logic [31:0] exc_target;
    logic        data_ar_busy;
    logic        fetch_axi_rvalid;
    logic [31:0] PC_buffer;
    logic        PC_AdEL;
    logic        PC_abnormal;

    int checks   = 0;
    int failures = 0;

    inst_req_stage_if bus ();

    inst_req_stage #(.RESET_ADDR(RST_PC)) dut (
        .clk              (clk),
        .rst              (rst),
        .PC_next          (PC_next),
        .IRWrite          (IRWrite),
        .decode_allowin   (decode_allowin),
        .IR_buffer_valid  (IR_buffer_valid),
        .exc_flush        (exc_flush),
        .exc_target       (exc_target),
        .data_ar_busy     (data_ar_busy),
        .bus              (bus.master),
        .fetch_axi_rvalid (fetch_axi_rvalid),
        .PC_buffer        (PC_buffer),
        .PC_AdEL          (PC_AdEL),
        .PC_abnormal      (PC_abnormal)
    );

    always #5 clk = ~clk;

    // Reference: one instruction transaction, tracked as
    // "address offered", "awaiting data", "data held for decode",
    // plus whether the outstanding transaction was killed by a flush.
    logic        m_ar, m_wait, m_have, m_kill;
    logic [31:0] m_pc;

    always @(posedge clk or posedge rst) begin : ref_model
        bit idle, resp, take, n_ar, n_wait, n_have, n_kill;
        if (rst) begin
            m_ar = 0; m_wait = 0; m_have = 0; m_kill = 0;
            m_pc = RST_PC;
        end else begin
            resp = bus.axi_rvalid && bus.axi_rready && bus.axi_rid == 0;
            idle = !m_ar && !m_wait && !m_have;
            take = m_have && IRWrite && decode_allowin && !IR_buffer_valid;
            n_ar = m_ar ? !bus.inst_arready
                        : (idle && !data_ar_busy && !exc_flush);
            n_wait = m_wait ? !resp : (m_ar && bus.inst_arready);
            n_have = m_have ? !(take || exc_flush)
                            : (m_wait && resp && !m_kill && !exc_flush);
            n_kill = (m_ar || (m_wait && !resp)) && (m_kill || exc_flush);
            if (exc_flush) m_pc = exc_target;
            else if (take) m_pc = PC_next;
            m_ar = n_ar; m_wait = n_wait; m_have = n_have; m_kill = n_kill;
        end
    end

    task automatic quiet;
        PC_next = RST_PC + 4; IRWrite = 0; decode_allowin = 0;
        IR_buffer_valid = 0; exc_flush = 0; exc_target = 0;
        data_ar_busy = 0;
        bus.inst_arready = 0; bus.axi_rvalid = 0;
        bus.axi_rid = 0; bus.axi_rready = 1;
    endtask

    task automatic step;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset(input logic busy);
        rst = 1;
        quiet();
        data_ar_busy = busy;
        repeat (2) @(negedge clk);
        rst = 0;
    endtask

    // IDLE -> AR -> R -> HOLD, leaving the beat held for decode
    task automatic to_hold;
        step();
        bus.inst_arready = 1;
        step();
        bus.inst_arready = 0;
        bus.axi_rvalid = 1; bus.axi_rid = 0;
        step();
        bus.axi_rvalid = 0;
    endtask

    task automatic test_reset;
        rst = 1;
        quiet();
        repeat (2) @(negedge clk);
        checks++;
        if (bus.inst_arvalid !== 1'b0 || bus.inst_araddr !== RST_PC ||
            PC_buffer !== RST_PC) begin
            failures++;
            $display("FAIL reset_regs arvalid=%b araddr=%h pc=%h exp 0 %h %h",
                     bus.inst_arvalid, bus.inst_araddr, PC_buffer,
                     RST_PC, RST_PC);
        end
        checks++;
        if (PC_AdEL !== 1'b0 || PC_abnormal !== 1'b0) begin
            failures++;
            $display("FAIL reset_adel adel=%b abn=%b exp 0 0",
                     PC_AdEL, PC_abnormal);
        end
        checks++;
        if (bus.inst_arid !== 3'd0 || bus.inst_arlen !== 8'd0 ||
            bus.inst_arsize !== 3'd2) begin
            failures++;
            $display("FAIL ar_consts id=%0d len=%0d size=%0d exp 0 0 2",
                     bus.inst_arid, bus.inst_arlen, bus.inst_arsize);
        end
        bus.axi_rvalid = 1; bus.axi_rid = 0;
        #1;
        checks++;
        if (fetch_axi_rvalid !== 1'b1) begin
            failures++;
            $display("FAIL reset_rvalid got=%b exp 1", fetch_axi_rvalid);
        end
        bus.axi_rvalid = 0;
    endtask

    task automatic test_first_fetch;
        do_reset(0);
        step();
        checks++;
        if (bus.inst_arvalid !== 1'b1 || bus.inst_araddr !== RST_PC) begin
            failures++;
            $display("FAIL first_ar arvalid=%b araddr=%h exp 1 %h",
                     bus.inst_arvalid, bus.inst_araddr, RST_PC);
        end
        bus.inst_arready = 1;
        step();
        bus.inst_arready = 0;
        checks++;
        if (bus.inst_arvalid !== 1'b0) begin
            failures++;
            $display("FAIL first_r arvalid=%b exp 0", bus.inst_arvalid);
        end
        bus.axi_rvalid = 1; bus.axi_rid = 0;
        #1;
        checks++;
        if (fetch_axi_rvalid !== 1'b1) begin
            failures++;
            $display("FAIL first_resp got=%b exp 1", fetch_axi_rvalid);
        end
        step();
        bus.axi_rvalid = 0;
        IRWrite = 1; decode_allowin = 1; PC_next = 32'hbfc00004;
        step();
        IRWrite = 0; decode_allowin = 0;
        checks++;
        if (PC_buffer !== 32'hbfc00004 || bus.inst_arvalid !== 1'b0) begin
            failures++;
            $display("FAIL first_adv pc=%h arvalid=%b exp bfc00004 0",
                     PC_buffer, bus.inst_arvalid);
        end
        step();
        checks++;
        if (bus.inst_arvalid !== 1'b1 ||
            bus.inst_araddr !== 32'hbfc00004) begin
            failures++;
            $display("FAIL second_ar arvalid=%b araddr=%h exp 1 bfc00004",
                     bus.inst_arvalid, bus.inst_araddr);
        end
    endtask

    task automatic test_busy;
        do_reset(1);
        for (int i = 0; i < 3; i++) begin
            step();
            checks++;
            if (bus.inst_arvalid !== 1'b0) begin
                failures++;
                $display("FAIL busy_block cyc=%0d arvalid=%b exp 0",
                         i, bus.inst_arvalid);
            end
        end
        data_ar_busy = 0;
        step();
        checks++;
        if (bus.inst_arvalid !== 1'b1) begin
            failures++;
            $display("FAIL busy_release arvalid=%b exp 1", bus.inst_arvalid);
        end
        data_ar_busy = 1;
        step();
        checks++;
        if (bus.inst_arvalid !== 1'b1) begin
            failures++;
            $display("FAIL busy_in_ar arvalid=%b exp 1", bus.inst_arvalid);
        end
    endtask

    task automatic test_hold_stall;
        do_reset(0);
        to_hold();
        PC_next = 32'hbfc00010;
        decode_allowin = 1;
        for (int i = 0; i < 5; i++) begin
            IRWrite = (i >= 2);
            IR_buffer_valid = (i >= 2);
            step();
            checks++;
            if (PC_buffer !== RST_PC || bus.inst_arvalid !== 1'b0) begin
                failures++;
                $display("FAIL hold_stall cyc=%0d pc=%h arvalid=%b exp %h 0",
                         i, PC_buffer, bus.inst_arvalid, RST_PC);
            end
        end
        IR_buffer_valid = 0;
        step();
        IRWrite = 0; decode_allowin = 0;
        checks++;
        if (PC_buffer !== 32'hbfc00010) begin
            failures++;
            $display("FAIL hold_release pc=%h exp bfc00010", PC_buffer);
        end
        step();
        checks++;
        if (bus.inst_arvalid !== 1'b1 ||
            bus.inst_araddr !== 32'hbfc00010) begin
            failures++;
            $display("FAIL hold_next_ar arvalid=%b araddr=%h exp 1 bfc00010",
                     bus.inst_arvalid, bus.inst_araddr);
        end
    endtask

    task automatic test_flush_r;
        do_reset(0);
        step();
        bus.inst_arready = 1;
        step();
        bus.inst_arready = 0;
        exc_flush = 1; exc_target = 32'hbfc00380;
        step();
        exc_flush = 0;
        checks++;
        if (PC_buffer !== 32'hbfc00380 || bus.inst_arvalid !== 1'b0) begin
            failures++;
            $display("FAIL flush_r_pc pc=%h arvalid=%b exp bfc00380 0",
                     PC_buffer, bus.inst_arvalid);
        end
        bus.axi_rvalid = 1; bus.axi_rid = 0;
        #1;
        checks++;
        if (fetch_axi_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL flush_r_drop got=%b exp 0", fetch_axi_rvalid);
        end
        step();
        bus.axi_rvalid = 0;
        step();
        checks++;
        if (bus.inst_arvalid !== 1'b1 ||
            bus.inst_araddr !== 32'hbfc00380) begin
            failures++;
            $display("FAIL flush_r_next arvalid=%b araddr=%h exp 1 bfc00380",
                     bus.inst_arvalid, bus.inst_araddr);
        end
    endtask

    task automatic test_flush_ar;
        do_reset(0);
        step();
        exc_flush = 1; exc_target = 32'hbfc00100;
        step();
        exc_flush = 0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus.inst_arvalid !== 1'b1 || PC_buffer !== 32'hbfc00100) begin
                failures++;
                $display("FAIL flush_ar_hold cyc=%0d arvalid=%b pc=%h exp 1 bfc00100",
                         i, bus.inst_arvalid, PC_buffer);
            end
            step();
        end
        bus.inst_arready = 1;
        step();
        bus.inst_arready = 0;
        bus.axi_rvalid = 1; bus.axi_rid = 0;
        #1;
        checks++;
        if (fetch_axi_rvalid !== 1'b0) begin
            failures++;
            $display("FAIL flush_ar_drop got=%b exp 0", fetch_axi_rvalid);
        end
        step();
        bus.axi_rvalid = 0;
        step();
        checks++;
        if (bus.inst_arvalid !== 1'b1 ||
            bus.inst_araddr !== 32'hbfc00100) begin
            failures++;
            $display("FAIL flush_ar_next arvalid=%b araddr=%h exp 1 bfc00100",
                     bus.inst_arvalid, bus.inst_araddr);
        end
    endtask

    task automatic test_flush_with_resp;
        do_reset(0);
        step();
        bus.inst_arready = 1;
        step();
        bus.inst_arready = 0;
        bus.axi_rvalid = 1; bus.axi_rid = 0;
        exc_flush = 1; exc_target = 32'hbfc00200;
        #1;
        checks++;
        if (fetch_axi_rvalid !== 1'b1) begin
            failures++;
            $display("FAIL coincide_pass got=%b exp 1", fetch_axi_rvalid);
        end
        step();
        exc_flush = 0; bus.axi_rvalid = 0;
        step();
        checks++;
        if (bus.inst_arvalid !== 1'b1 ||
            bus.inst_araddr !== 32'hbfc00200) begin
            failures++;
            $display("FAIL coincide_next arvalid=%b araddr=%h exp 1 bfc00200",
                     bus.inst_arvalid, bus.inst_araddr);
        end
    endtask

    task automatic test_misaligned;
        do_reset(0);
        to_hold();
        IRWrite = 1; decode_allowin = 1; PC_next = 32'hbfc00006;
        step();
        IRWrite = 0; decode_allowin = 0;
        checks++;
        if (PC_AdEL !== 1'b1 || PC_abnormal !== 1'b1 ||
            PC_buffer !== 32'hbfc00006) begin
            failures++;
            $display("FAIL misalign_flag adel=%b abn=%b pc=%h exp 1 1 bfc00006",
                     PC_AdEL, PC_abnormal, PC_buffer);
        end
        step();
        checks++;
        if (bus.inst_arvalid !== 1'b1 ||
            bus.inst_araddr !== 32'hbfc00004) begin
            failures++;
            $display("FAIL misalign_addr arvalid=%b araddr=%h exp 1 bfc00004",
                     bus.inst_arvalid, bus.inst_araddr);
        end
        exc_flush = 1; exc_target = 32'hbfc00300;
        step();
        exc_flush = 0;
        bus.axi_rvalid = 1; bus.axi_rid = 3'd2;
        #1;
        checks++;
        if (fetch_axi_rvalid !== 1'b1) begin
            failures++;
            $display("FAIL other_id_pass got=%b exp 1", fetch_axi_rvalid);
        end
        bus.axi_rvalid = 0; bus.axi_rid = 0;
    endtask

    task automatic test_random;
        bit exp_rv;
        do_reset(0);
        for (int i = 0; i < 600; i++) begin
            checks++;
            if (bus.inst_arvalid !== m_ar ||
                bus.inst_araddr !== {m_pc[31:2], 2'b00} ||
                PC_buffer !== m_pc ||
                PC_AdEL !== (m_pc[1:0] != 2'b00) ||
                PC_abnormal !== (m_pc[1:0] != 2'b00)) begin
                failures++;
                $display("FAIL rand_regs cyc=%0d arvalid=%b/%b araddr=%h/%h pc=%h/%h adel=%b",
                         i, bus.inst_arvalid, m_ar, bus.inst_araddr,
                         {m_pc[31:2], 2'b00}, PC_buffer, m_pc, PC_AdEL);
            end
            data_ar_busy     = ($urandom % 4) == 0;
            bus.inst_arready = ($urandom % 2) == 0;
            bus.axi_rready   = ($urandom % 4) != 0;
            if (m_wait) begin
                bus.axi_rvalid = ($urandom % 2) == 0;
                bus.axi_rid = (($urandom % 4) == 0)
                            ? 3'($urandom_range(1, 7)) : 3'd0;
            end else begin
                bus.axi_rvalid = ($urandom % 3) == 0;
                bus.axi_rid = 3'($urandom_range(1, 7));
            end
            IRWrite         = ($urandom % 4) != 0;
            decode_allowin  = ($urandom % 4) != 0;
            IR_buffer_valid = ($urandom % 4) == 0;
            exc_flush       = ($urandom % 10) == 0;
            exc_target      = $urandom;
            PC_next         = $urandom;
            #1;
            exp_rv = bus.axi_rvalid && !(bus.axi_rid == 0 && m_kill);
            checks++;
            if (fetch_axi_rvalid !== exp_rv) begin
                failures++;
                $display("FAIL rand_rvalid cyc=%0d got=%b exp=%b",
                         i, fetch_axi_rvalid, exp_rv);
            end
            @(negedge clk);
        end
        quiet();
    endtask

    initial begin
        test_reset();
        test_first_fetch();
        test_busy();
        test_hold_stall();
        test_flush_r();
        test_flush_ar();
        test_flush_with_resp();
        test_misaligned();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/inst_req_stage.md
# inst_req_stage

Instruction-request stage directly upstream of the fetch stage. Owns the architectural fetch PC, issues single-beat AXI read-address requests (ID 0) for instructions, and tracks each request until its read data has been handed over. It supplies the fetch stage with the PC of the in-flight instruction and the address-error flag. It also gates the R-channel valid so that responses to requests cancelled by an exception flush never reach the fetch stage.

## Interface
- `RESET_ADDR`, default 32'hbfc00000: PC after reset.
- `clk` in 1: single clock for the block.
- `rst` in 1: reset, asynchronous, active-high.
- `PC_next` in 32: sequential or branch next PC, computed by decode.
- `IRWrite` in 1: decode is not stalled.
- `decode_allowin` in 1: decode accepts a new instruction.
- `IR_buffer_valid` in 1: fetch stage holds a buffered instruction.
- `exc_flush` in 1: exception or ERET redirect, one-cycle pulse.
- `exc_target` in 32: redirect PC.
- `data_ar_busy` in 1: data side owns the AR channel this cycle.
- `inst_arvalid` out 1, `inst_araddr` out 32, `inst_arid` out 3 (constant 0), `inst_arlen` out 8 (constant 0), `inst_arsize` out 3 (constant 2).
- `inst_arready` in 1.
- `axi_rvalid` in 1, `axi_rid` in 3, `axi_rready` in 1: raw R channel plus the rready driven by fetch.
- `fetch_axi_rvalid` out 1: gated rvalid to the fetch stage.
- `PC_buffer` out 32: PC of the current request.
- `PC_AdEL` out 1: PC_buffer[1:0] != 0.
- `PC_abnormal` out 1: equals PC_AdEL.

## Operation
- State machine with four states:
  - IDLE: not yet issuing.
  - AR: address phase.
  - R: waiting for data.
  - HOLD: data delivered, waiting for decode to take it.
- Registers: `pc`, `state`, `drop`.
- `PC_buffer` = `pc`. `inst_araddr` = {pc[31:2], 2'b00}. A misaligned PC is still fetched at the aligned address; only PC_AdEL flags the fault.
- `inst_arvalid` = (state == AR).
- `inst_resp` = axi_rvalid && axi_rready && axi_rid == 0.
- `fetch_axi_rvalid` = axi_rvalid && !(axi_rid == 0 && drop). Responses with a non-zero ID always pass through.
- Transitions:
  - IDLE → AR when !data_ar_busy.
  - AR → R on inst_arready.
  - R, drop == 0: → HOLD on inst_resp.
  - R, drop == 1: on inst_resp, drop ← 0 and → IDLE. The response is swallowed.
  - HOLD → IDLE when IRWrite && decode_allowin && !IR_buffer_valid, with pc ← PC_next.
- exc_flush, applied in any state:
  - pc ← exc_target.
  - IDLE or HOLD: → IDLE with no pending response.
  - AR or R: drop ← 1 and the state continues normally. arvalid is never retracted once raised, per the AXI rule.
- Priority: exc_flush over the HOLD advance; the HOLD advance over holding.
- In IDLE, data_ar_busy blocks only the *start* of a request. Once in AR, data_ar_busy is ignored.

## Timing
- Reset values: state = IDLE, pc = RESET_ADDR, drop = 0, inst_arvalid = 0.
- Reset outputs: inst_araddr = RESET_ADDR, PC_buffer = RESET_ADDR, PC_AdEL = 0, PC_abnormal = 0, fetch_axi_rvalid follows its equation.
- First request: arvalid rises in the cycle after reset deasserts if data_ar_busy = 0 (IDLE→AR takes one edge).
- Best-case loop per instruction, IDLE → AR → R → HOLD → IDLE, is 4 cycles (zero-wait slave, immediate decode accept).
- pc and PC_buffer change only on the HOLD advance or on exc_flush. They stay stable from AR entry through R, so the fetch stage latches the correct PC with the data.
- Reset asserted mid-transaction clears everything. Stale slave responses after reset are out of scope; the interconnect is reset together with this block.
- A flush in the same cycle as inst_resp in state R: that response is dropped (fetch_axi_rvalid = 0 combinationally only if drop was already set). The flush sets drop only if the response is still pending after this edge. If inst_resp and the flush coincide in R with drop = 0, the response passes to fetch. Decode's own flush kills it; this block moves to IDLE with pc = exc_target.
- A second flush while drop = 1 only reloads pc.

## Structure
- Shared package: RESET_ADDR, the AXI constants (ARID_INST = 0, ARLEN_SINGLE = 0, ARSIZE_WORD = 2), and the state encoding (IDLE = 2'd0, AR = 2'd1, R = 2'd2, HOLD = 2'd3).
- Single flat module; no sub-module needed.

## Test plan
- Reset release with data_ar_busy = 0: arvalid = 1 next cycle, araddr = bfc00000. arready and then rid = 0 data → HOLD. Decode accepts with PC_next = bfc00004 → next araddr = bfc00004.
- data_ar_busy held for 3 cycles in IDLE: arvalid stays 0 throughout and rises in the cycle after busy drops.
- Stall in HOLD (IRWrite = 0 or IR_buffer_valid = 1) for 5 cycles: PC_buffer holds and no new arvalid. On release, pc = PC_next.
- exc_flush in state R, target bfc00380: the following rid = 0 response gives fetch_axi_rvalid = 0. The next request has araddr = bfc00380.
- exc_flush in AR while arready = 0: arvalid remains 1 until the handshake, the response is dropped, and the next araddr = exc_target.
- PC_next = bfc00006: PC_AdEL = 1, PC_abnormal = 1, araddr = bfc00004. A rid = 2 response in any state passes unchanged to fetch_axi_rvalid.
